// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side initiator for a 32x32 word data RAM.
// Turns byte/halfword/word loads and stores into single-word RAM accesses.
// Sub-word stores are done as read-modify-write. Loads are lane-extracted
// and then sign- or zero-extended. All outputs are registered, and the
// asynchronous reset clears them at once.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [6:0]  addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        addr_err,
    output logic [31:0] rdata,
    output logic        ram_ena,
    output logic        wena,
    output logic [4:0]  ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [6:0]  addr_q;
    logic [15:0] wdata_q;   // only sub-word stores revisit the data after IDLE

    // Alignment rule: halfwords need an even address, words need a multiple of 4.
    // The reserved size code 11 is always rejected.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    // Replace one little-endian byte or halfword lane of the read word.
    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] data,
                                               input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] res;
        res = word;
        if (sz == 2'b00) begin
            case (lane)
                2'd0:    res[7:0]   = data[7:0];
                2'd1:    res[15:8]  = data[7:0];
                2'd2:    res[23:16] = data[7:0];
                default: res[31:24] = data[7:0];
            endcase
        end else if (lane[1]) begin
            res[31:16] = data;
        end else begin
            res[15:0] = data;
        end
        return res;
    endfunction

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] lane, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   res = {{24{sx & b[7]}}, b};
            2'b01:   res = {{16{sx & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // The word address always follows the latched request.
    assign ram_addr = addr_q[6:2];

    // Access FSM. Each output is set on the edge that enters the state it
    // belongs to, so it is stable for that whole cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            sext_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            addr_err <= 1'b0;
            rdata    <= '0;
            ram_ena  <= 1'b0;
            wena     <= 1'b0;
            ram_din  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        sext_q  <= sext;
                        addr_q  <= addr;
                        wdata_q <= wdata[15:0];
                        busy    <= 1'b1;
                        if (misaligned(size, addr[1:0])) begin
                            state    <= RESP;
                            done     <= 1'b1;
                            addr_err <= 1'b1;
                        end else if (we && size == 2'b10) begin
                            state   <= WR;
                            ram_ena <= 1'b1;
                            wena    <= 1'b1;
                            ram_din <= wdata;
                        end else begin
                            state   <= RD;
                            ram_ena <= 1'b1;
                            wena    <= 1'b0;
                        end
                    end
                end
                RD: begin
                    // The read data is consumed here and only here.
                    if (we_q) begin
                        state   <= WR;
                        wena    <= 1'b1;
                        ram_din <= merge_lane(ram_dout, wdata_q, size_q, addr_q[1:0]);
                    end else begin
                        state    <= RESP;
                        ram_ena  <= 1'b0;
                        done     <= 1'b1;
                        addr_err <= 1'b0;
                        rdata    <= extract_lane(ram_dout, size_q, addr_q[1:0], sext_q);
                    end
                end
                WR: begin
                    state    <= RESP;
                    ram_ena  <= 1'b0;
                    wena     <= 1'b0;
                    ram_din  <= '0;
                    done     <= 1'b1;
                    addr_err <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    addr_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. It contains a behavioural 32x32 RAM,
// a table of single requests, and hand-written sequences for held req
// and for reset during a write.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        addr_err;
    logic [31:0] rdata;
    logic        ram_ena;
    logic        wena;
    logic [4:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    int errors = 0;
    int checks = 0;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .addr_err(addr_err),
        .rdata(rdata), .ram_ena(ram_ena), .wena(wena), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM model. When the RAM is disabled it returns a garbage pattern, so
    // sampling outside RD would corrupt results.
    logic [31:0] mem [32];
    always @(posedge clk) if (ram_ena && wena) mem[ram_addr] <= ram_din;
    assign ram_dout = ram_ena ? mem[ram_addr] : 32'hBADC0FFE;

    // Bus activity monitor, sampled mid-cycle.
    int          ena_cnt = 0;
    int          wena_cnt = 0;
    logic [31:0] last_din = '0;
    logic [4:0]  last_waddr = '0;
    always @(negedge clk) begin
        if (ram_ena) ena_cnt <= ena_cnt + 1;
        if (wena) begin
            wena_cnt   <= wena_cnt + 1;
            last_din   <= ram_din;
            last_waddr <= ram_addr;
        end
    end

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sx;
        logic [6:0]  a;
        logic [31:0] d;
        int          lat;
        logic        err;
        logic [31:0] rd;
        int          ne;
        int          nw;
        logic [31:0] din;
        logic [4:0]  wa;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic w, input logic [1:0] sz, input logic sx,
                                input logic [6:0] a, input logic [31:0] d, input int lat,
                                input logic err, input logic [31:0] rd, input int ne,
                                input int nw, input logic [31:0] din, input logic [4:0] wa);
        vec_t v;
        v = '{w, sz, sx, a, d, lat, err, rd, ne, nw, din, wa};
        tbl.push_back(v);
    endfunction

    // Wait mid-cycle for done, with a bound. Latency counts cycles after the accept edge.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
            if (done) break;
        end
    endtask

    task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [6:0] a, input logic [31:0] d,
                          output int lat, output logic e, output logic [31:0] rd,
                          output int ne, output int nw);
        int e0, w0;
        @(negedge clk);
        we = w; size = sz; sext = sx; addr = a; wdata = d; req = 1'b1;
        #1;
        e0 = ena_cnt;
        w0 = wena_cnt;
        @(posedge clk);
        #1 req = 1'b0;
        wait_done(lat);
        e  = addr_err;
        rd = rdata;
        ne = ena_cnt - e0;
        nw = wena_cnt - w0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_addr_err"}, addr_err, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_ram_ena"}, ram_ena, 0);
        chk({tag, "_wena"}, wena, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_din"}, ram_din, 0);
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [31:0] rd;
        int          ne, nw;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
        addr = '0; wdata = '0;

        //   w  sz     sx a      d              lat err rd            ne nw din           wa
        add(1, 2'b10, 0, 7'h08, 32'hDEADBEEF, 2, 0, 32'h00000000, 1, 1, 32'hDEADBEEF, 5'd2);
        add(0, 2'b10, 0, 7'h08, 32'h00000000, 2, 0, 32'hDEADBEEF, 1, 0, 32'h0, 5'd0);
        add(1, 2'b10, 0, 7'h10, 32'h11223344, 2, 0, 32'hDEADBEEF, 1, 1, 32'h11223344, 5'd4);
        add(1, 2'b00, 0, 7'h12, 32'hFFFFFFAA, 3, 0, 32'hDEADBEEF, 2, 1, 32'h11AA3344, 5'd4);
        add(0, 2'b10, 0, 7'h10, 32'h00000000, 2, 0, 32'h11AA3344, 1, 0, 32'h0, 5'd0);
        add(1, 2'b10, 0, 7'h20, 32'h8000F07F, 2, 0, 32'h11AA3344, 1, 1, 32'h8000F07F, 5'd8);
        add(0, 2'b00, 1, 7'h20, 32'h00000000, 2, 0, 32'h0000007F, 1, 0, 32'h0, 5'd0);
        add(0, 2'b00, 1, 7'h21, 32'h00000000, 2, 0, 32'hFFFFFFF0, 1, 0, 32'h0, 5'd0);
        add(0, 2'b01, 1, 7'h22, 32'h00000000, 2, 0, 32'hFFFF8000, 1, 0, 32'h0, 5'd0);
        add(0, 2'b01, 0, 7'h22, 32'h00000000, 2, 0, 32'h00008000, 1, 0, 32'h0, 5'd0);
        add(0, 2'b01, 1, 7'h05, 32'h00000000, 1, 1, 32'h00008000, 0, 0, 32'h0, 5'd0);
        add(1, 2'b10, 0, 7'h0A, 32'h12345678, 1, 1, 32'h00008000, 0, 0, 32'h0, 5'd0);
        add(0, 2'b11, 0, 7'h00, 32'h00000000, 1, 1, 32'h00008000, 0, 0, 32'h0, 5'd0);
        add(1, 2'b01, 0, 7'h12, 32'h1234BEEF, 3, 0, 32'h00008000, 2, 1, 32'hBEEF3344, 5'd4);
        add(0, 2'b00, 0, 7'h13, 32'h00000000, 2, 0, 32'h000000BE, 1, 0, 32'h0, 5'd0);
        add(0, 2'b00, 1, 7'h13, 32'h00000000, 2, 0, 32'hFFFFFFBE, 1, 0, 32'h0, 5'd0);
        add(0, 2'b01, 0, 7'h10, 32'h00000000, 2, 0, 32'h00003344, 1, 0, 32'h0, 5'd0);
        add(0, 2'b00, 1, 7'h12, 32'h00000000, 2, 0, 32'hFFFFFFEF, 1, 0, 32'h0, 5'd0);
        add(1, 2'b00, 0, 7'h23, 32'h00000012, 3, 0, 32'hFFFFFFEF, 2, 1, 32'h1200F07F, 5'd8);
        add(0, 2'b10, 0, 7'h20, 32'h00000000, 2, 0, 32'h1200F07F, 1, 0, 32'h0, 5'd0);
        add(1, 2'b01, 0, 7'h13, 32'h0000CAFE, 1, 1, 32'h1200F07F, 0, 0, 32'h0, 5'd0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Single-request vectors
        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i].w, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].d, lat, e, rd, ne, nw);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_addr_err", i), e, tbl[i].err);
            chk($sformatf("v%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("v%0d_ena_cycles", i), ne, tbl[i].ne);
            chk($sformatf("v%0d_wena_cycles", i), nw, tbl[i].nw);
            if (tbl[i].nw == 1) begin
                chk($sformatf("v%0d_ram_din", i), last_din, tbl[i].din);
                chk($sformatf("v%0d_ram_addr", i), last_waddr, tbl[i].wa);
            end
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_idle", i), busy, 0);
        end

        // req held high across a byte store while addr/wdata change
        run_op(1, 2'b10, 0, 7'h18, 32'h00000000, lat, e, rd, ne, nw);
        chk("hold_init_latency", lat, 2);
        @(negedge clk);
        we = 1'b1; size = 2'b00; sext = 1'b0; addr = 7'h19; wdata = 32'h00000077; req = 1'b1;
        @(posedge clk);
        #1;
        addr = 7'h1A; wdata = 32'h00000066;
        wait_done(lat);
        chk("hold_first_latency", lat, 3);
        @(negedge clk);
        #1;
        chk("hold_not_accepted_in_resp", busy, 0);
        chk("hold_idle_done_low", done, 0);
        @(posedge clk);
        #1 req = 1'b0;
        chk("hold_second_accepted", busy, 1);
        wait_done(lat);
        chk("hold_second_latency", lat, 3);
        run_op(0, 2'b10, 0, 7'h18, 32'h0, lat, e, rd, ne, nw);
        chk("hold_result", rd, 32'h00667700);

        // Reset during the WR cycle of a byte store
        run_op(1, 2'b10, 0, 7'h00, 32'h55555555, lat, e, rd, ne, nw);
        chk("rstwr_init_latency", lat, 2);
        @(negedge clk);
        we = 1'b1; size = 2'b00; sext = 1'b0; addr = 7'h00; wdata = 32'h000000AA; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #2;
        chk("rstwr_in_wr", wena, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rstwr_async");
        @(posedge clk);
        #1;
        chk_reset_outputs("rstwr_held");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 2'b10, 0, 7'h00, 32'h0, lat, e, rd, ne, nw);
        chk("rstwr_latency", lat, 2);
        chk("rstwr_no_write", rd, 32'h55555555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
